// File: rtl/mips_pipe_pkg.sv
// Shared types and helpers for the MIPS pipeline hazard control slice.
package mips_pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN,
        MD_BUSY
    } md_state_e;

    // Increment enable that refuses to step a counter which already reads all-ones.
    function automatic logic sat_inc_en(input logic inc, input logic all_ones);
        return inc & ~all_ones;
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO unit busy window: stays busy for MdLatency cycles after a mult/div is accepted.
module md_busy_timer
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MdLatency = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic accept_i,
    output logic md_busy_o
);

    localparam logic [7:0] LoadVal = 8'(MdLatency - 1);

    md_state_e  state_q;
    logic [7:0] cnt_q;
    logic       busy_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (accept_i) begin
                        state_q <= MD_BUSY;
                        cnt_q   <= LoadVal;
                        busy_q  <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign md_busy_o = busy_q;

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline with saturating perf counters.
module mips_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    input  logic             branch_D,
    input  logic             pc_src_D,
    input  logic             md_op_D,
    input  logic             mfhilo_D,
    input  logic [REG_W-1:0] rt_E,
    input  logic [REG_W-1:0] write_reg_E,
    input  logic             reg_write_E,
    input  logic             mem_to_reg_E,
    input  logic [REG_W-1:0] write_reg_M,
    input  logic             mem_to_reg_M,
    input  logic             imem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             flush_E,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic lw_h, br_h, md_h, if_h, hold_d;
    logic src_e_hit, src_m_hit, lw_hit;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Register 0 is hardwired, so a producer targeting it never creates a hazard.
    assign lw_hit    = (rt_E != REG_ZERO) && ((rt_E == rs_D) || (rt_E == rt_D));
    assign src_e_hit = (write_reg_E != REG_ZERO) &&
                       ((write_reg_E == rs_D) || (write_reg_E == rt_D));
    assign src_m_hit = (write_reg_M != REG_ZERO) &&
                       ((write_reg_M == rs_D) || (write_reg_M == rt_D));

    assign lw_h   = mem_to_reg_E & lw_hit;
    assign br_h   = branch_D & ((reg_write_E & src_e_hit) | (mem_to_reg_M & src_m_hit));
    assign md_h   = md_busy & (md_op_D | mfhilo_D);
    assign if_h   = ~imem_ready;
    assign hold_d = lw_h | br_h | md_h;

    always_comb begin
        stall_D = 1'b0;
        stall_F = 1'b0;
        flush_E = 1'b1;
        flush_D = 1'b1;
        if (!rst) begin
            stall_D = hold_d;
            stall_F = hold_d | if_h;
            flush_E = hold_d;
            flush_D = ~hold_d & (pc_src_D | if_h);
        end
    end

    md_busy_timer #(
        .MdLatency (MD_LATENCY)
    ) u_md_busy_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .accept_i  (md_op_D & ~hold_d),
        .md_busy_o (md_busy)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(sat_inc_en(hold_d, &stall_cnt_q));
        flush_cnt_d = flush_cnt_q + CNT_W'(sat_inc_en(pc_src_D & ~hold_d, &flush_cnt_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl with MD_LATENCY=4 and 4-bit counters.
module tb_mips_hazard_ctrl;

    localparam int unsigned CntW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_D, rt_D, rt_E, write_reg_E, write_reg_M;
    logic       branch_D, pc_src_D, md_op_D, mfhilo_D;
    logic       reg_write_E, mem_to_reg_E, mem_to_reg_M, imem_ready;
    logic       stall_F, stall_D, flush_D, flush_E, md_busy;
    logic [CntW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_hazard_ctrl #(
        .MD_LATENCY (4),
        .CNT_W      (CntW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs_D         (rs_D),
        .rt_D         (rt_D),
        .branch_D     (branch_D),
        .pc_src_D     (pc_src_D),
        .md_op_D      (md_op_D),
        .mfhilo_D     (mfhilo_D),
        .rt_E         (rt_E),
        .write_reg_E  (write_reg_E),
        .reg_write_E  (reg_write_E),
        .mem_to_reg_E (mem_to_reg_E),
        .write_reg_M  (write_reg_M),
        .mem_to_reg_M (mem_to_reg_M),
        .imem_ready   (imem_ready),
        .stall_F      (stall_F),
        .stall_D      (stall_D),
        .flush_D      (flush_D),
        .flush_E      (flush_E),
        .md_busy      (md_busy),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rs_D = 5'd0; rt_D = 5'd0; rt_E = 5'd0; write_reg_E = 5'd0; write_reg_M = 5'd0;
        branch_D = 1'b0; pc_src_D = 1'b0; md_op_D = 1'b0; mfhilo_D = 1'b0;
        reg_write_E = 1'b0; mem_to_reg_E = 1'b0; mem_to_reg_M = 1'b0; imem_ready = 1'b1;
    endtask

    // Advance to the next falling edge with idle inputs; outputs settle 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
        idle_inputs();
        #1;
    endtask

    task automatic check_outs(input string tag, input logic sf, input logic sd,
                              input logic fd, input logic fe);
        check({tag, ".stall_F"}, 32'(stall_F), 32'(sf));
        check({tag, ".stall_D"}, 32'(stall_D), 32'(sd));
        check({tag, ".flush_D"}, 32'(flush_D), 32'(fd));
        check({tag, ".flush_E"}, 32'(flush_E), 32'(fe));
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        // Reset overrides even a live load-use hazard.
        @(negedge clk);
        mem_to_reg_E = 1'b1; rt_E = 5'd8; rs_D = 5'd8;
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        check("reset.md_busy", 32'(md_busy), 32'd0);
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset.flush_cnt", 32'(flush_cnt), 32'd0);
        rst = 1'b0;

        // Load-use: one stall cycle, then release.
        @(negedge clk);
        mem_to_reg_E = 1'b1; rt_E = 5'd8; rs_D = 5'd8;
        #1;
        check_outs("lw", 1'b1, 1'b1, 1'b0, 1'b1);
        next_cycle();
        check_outs("lw_rel", 1'b0, 1'b0, 1'b0, 1'b0);
        check("lw.stall_cnt", 32'(stall_cnt), 32'd1);

        // Load into $zero never stalls.
        @(negedge clk);
        mem_to_reg_E = 1'b1; rt_E = 5'd0; rs_D = 5'd0;
        #1;
        check_outs("lw_zero", 1'b0, 1'b0, 1'b0, 1'b0);

        // Branch operand hazards from E then M; stale pc_src_D must not flush.
        @(negedge clk);
        branch_D = 1'b1; rs_D = 5'd9; reg_write_E = 1'b1; write_reg_E = 5'd9; pc_src_D = 1'b1;
        #1;
        check_outs("br_E", 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        idle_inputs();
        branch_D = 1'b1; rs_D = 5'd9; mem_to_reg_M = 1'b1; write_reg_M = 5'd9; pc_src_D = 1'b1;
        #1;
        check_outs("br_M", 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        idle_inputs();
        branch_D = 1'b1; rs_D = 5'd9; pc_src_D = 1'b1;
        #1;
        check_outs("br_taken", 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        check("br.flush_cnt", 32'(flush_cnt), 32'd1);
        check("br.stall_cnt", 32'(stall_cnt), 32'd3);

        // mult accepted, then mfhi held for exactly 4 cycles.
        @(negedge clk);
        md_op_D = 1'b1;
        #1;
        check("md_accept.stall_D", 32'(stall_D), 32'd0);
        check("md_accept.md_busy", 32'(md_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            mfhilo_D = 1'b1;
            #1;
            check($sformatf("md_wait%0d.md_busy", i), 32'(md_busy), 32'd1);
            check($sformatf("md_wait%0d.stall_D", i), 32'(stall_D), 32'd1);
        end
        @(negedge clk);
        idle_inputs();
        mfhilo_D = 1'b1;
        #1;
        check("md_done.md_busy", 32'(md_busy), 32'd0);
        check("md_done.stall_D", 32'(stall_D), 32'd0);
        next_cycle();
        check("md.stall_cnt", 32'(stall_cnt), 32'd7);

        // Instruction-memory wait alone: fetch held, decode cleared.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            imem_ready = 1'b0;
            #1;
            check_outs($sformatf("if_wait%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
        end
        // Wait with a load-use hazard: hold beats clear.
        @(negedge clk);
        idle_inputs();
        imem_ready = 1'b0; mem_to_reg_E = 1'b1; rt_E = 5'd4; rt_D = 5'd4;
        #1;
        check_outs("if_lw", 1'b1, 1'b1, 1'b0, 1'b1);
        // Taken branch during wait: one flush.
        @(negedge clk);
        idle_inputs();
        imem_ready = 1'b0; pc_src_D = 1'b1;
        #1;
        check_outs("if_br", 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        check("if.stall_cnt", 32'(stall_cnt), 32'd8);
        check("if.flush_cnt", 32'(flush_cnt), 32'd2);

        // Reset in the second busy cycle aborts the window.
        @(negedge clk);
        md_op_D = 1'b1;
        #1;
        next_cycle();
        check("rst_mid.busy1", 32'(md_busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid.busy2", 32'(md_busy), 32'd1);
        check_outs("rst_mid", 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid.md_busy", 32'(md_busy), 32'd0);
        check("rst_mid.stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_mid.flush_cnt", 32'(flush_cnt), 32'd0);

        // Saturation: 20 stall cycles on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idle_inputs();
            mem_to_reg_E = 1'b1; rt_E = 5'd8; rs_D = 5'd8;
            #1;
            if (i == 15) check("sat15.stall_cnt", 32'(stall_cnt), 32'd15);
        end
        next_cycle();
        check("sat20.stall_cnt", 32'(stall_cnt), 32'd15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_hazard_ctrl.md
Name: mips_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the IF/ID register hold (stall) and clear, PC hold, and the ID/EX bubble.
- Detects load-use, branch-in-decode operand hazards, multiply/divide busy hazards and instruction-memory wait.
- Keeps saturating stall and flush performance counters.

Parameters:
- MD_LATENCY, 4: cycles the HI/LO unit stays busy after a mult/div is accepted (legal range 1..255).
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rs_D  in  5  decode-stage source register rs
- rt_D  in  5  decode-stage source register rt
- branch_D  in  1  decode instruction is a branch (beq/bne)
- pc_src_D  in  1  branch resolved taken in decode
- md_op_D  in  1  decode instruction is mult/multu/div/divu
- mfhilo_D  in  1  decode instruction is mfhi/mflo
- rt_E  in  5  execute-stage rt
- write_reg_E  in  5  execute-stage destination register
- reg_write_E  in  1  execute-stage writes the register file
- mem_to_reg_E  in  1  execute-stage instruction is a load
- write_reg_M  in  5  memory-stage destination register
- mem_to_reg_M  in  1  memory-stage instruction is a load
- imem_ready  in  1  instruction memory returns valid instr_F this cycle
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID (stall input of the IF/ID register)
- flush_D  out  1  synchronous clear of IF/ID
- flush_E  out  1  synchronous clear of ID/EX (bubble)
- md_busy  out  1  HI/LO unit busy
- stall_cnt  out  CNT_W  cycles with stall_D=1
- flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Clock and reset: clock is clk. Reset rst is synchronous and active-high.
- During rst=1 and after it:
  - stall_F=0, stall_D=0, flush_D=1, flush_E=1. This clears the pipeline while reset is held.
  - State is RUN, the latency counter is 0, md_busy=0, and both performance counters are 0.
  - rst mid-MD_BUSY aborts the busy window immediately.
- Hazard terms (combinational). A match against register 0 never counts.
  - lw_h = mem_to_reg_E & (rt_E==rs_D | rt_E==rt_D).
  - br_h = branch_D & ((reg_write_E & write_reg_E matches rs_D/rt_D) | (mem_to_reg_M & write_reg_M matches rs_D/rt_D)).
  - md_h = md_busy & (md_op_D | mfhilo_D).
  - if_h = ~imem_ready.
- Outputs (combinational from state and inputs; rst overrides):
  - stall_D = lw_h | br_h | md_h.
  - stall_F = stall_D | if_h.
  - flush_E = stall_D.
  - flush_D = ~stall_D & (pc_src_D | if_h).
  - When stall_D=1, flush_D=0: a hold always beats a clear.
  - pc_src_D is ignored while br_h=1, because the branch operands are stale.
- State machine, 2 states:
  - RUN -> MD_BUSY when md_op_D & ~stall_D. The latency counter loads MD_LATENCY-1.
  - MD_BUSY: the counter decrements on every edge. When the counter is 0 at an edge, the next state is RUN.
  - md_busy = (state==MD_BUSY). It is high for exactly MD_LATENCY cycles after the accept cycle.
  - A new md_op_D arriving while busy is stalled through md_h. It is accepted in the first RUN cycle, which reloads the counter.
- Simultaneous events:
  - lw_h and br_h in the same cycle give a single stall.
  - if_h with stall_D=1: the decode instruction is held, not cleared.
  - pc_src_D with if_h=1: a single flush_D.
- Counters:
  - stall_cnt increments in each cycle with stall_D=1.
  - flush_cnt increments in each cycle with pc_src_D & ~stall_D.
  - Both saturate at all-ones and never wrap.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - the state enum {RUN, MD_BUSY};
  - REG_ZERO = 5'd0;
  - register-index width 5;
  - the counter saturation helper function.
- One sub-module, md_busy_timer, holds the state, latency counter and md_busy output. Hazard decode and output logic stay in the top module.

Test Plan:
- lw $t0 in E (mem_to_reg_E=1, rt_E=8) with rs_D=8 -> exactly one cycle of stall_F=stall_D=flush_E=1, then release; stall_cnt=1.
- rt_E=0, mem_to_reg_E=1, rs_D=0 -> no stall.
- branch_D=1, rs_D=9, reg_write_E=1, write_reg_E=9 -> stall 1 cycle. The next cycle has mem_to_reg_M=1, write_reg_M=9 -> stall again. Then pc_src_D=1 -> flush_D=1 for one cycle; flush_cnt=1.
- MD_LATENCY=4: mult accepted, then mfhi in D -> md_busy=1 and stall_D=1 for 4 cycles; mfhi advances in cycle 5.
- imem_ready=0 for 3 cycles with no hazard -> stall_F=1, flush_D=1, stall_D=0 for those 3 cycles. Repeat with lw_h active -> flush_D=0 and stall_D=1.
- rst asserted in the 2nd MD_BUSY cycle -> next cycle md_busy=0, counters 0, flush_D=flush_E=1. With CNT_W=4 and 20 stall cycles -> stall_cnt holds at 15.
